fcvtint_seq: RTL and testbench

//  Sequencer for the FP->integer conversion post-processing datapath (round/negate/MSB-select unit).
//  - Accepts one conversion op per valid/ready handshake and holds operands stable while the datapath evaluates.
//  - Registers the datapath result, checks for overflow and substitutes the RISC-V saturation value.
//  - Returns the final XLEN result plus NV/NX flags to the FPU writeback stage over a valid/ready handshake.

---
 rtl/fcvtint_seq.sv | 134 +++++++++++++
 tb/tb_fcvtint_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fcvtint_seq.sv
// fcvtint_seq: sequencer for the FP->integer conversion round/negate/MSB-select datapath
// Ports:
//   clk, reset_n (async, active-low), Flush (drop the in-flight op, no response)
//   Req*  : op request handshake (ReqValid/ReqReady) plus operand and control fields
//   Dp*   : registered operands out to the external datapath, DpNegRes/DpNegResMsbs back
//   Rsp*  : result handshake (RspValid/RspReady), RspRes, RspNV, RspNX
//   OvfCount : present only when FCVTINT_OVFCNT_EN is defined; counts accepted NV responses
module fcvtint_seq #(
    parameter int XLEN        = 64,
    parameter int NORMSHIFTSZ = 110
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   Flush,
    input  logic                   ReqValid,
    output logic                   ReqReady,
    input  logic                   ReqSigned,
    input  logic                   ReqInt64,
    input  logic                   ReqPlus1,
    input  logic                   ReqXs,
    input  logic                   ReqNaN,
    input  logic                   ReqForceOvf,
    input  logic                   ReqInexact,
    input  logic [NORMSHIFTSZ-1:0] ReqShifted,
    output logic                   DpSigned,
    output logic                   DpInt64,
    output logic                   DpPlus1,
    output logic                   DpXs,
    output logic [NORMSHIFTSZ-1:0] DpShifted,
    input  logic [XLEN+1:0]        DpNegRes,
    input  logic [1:0]             DpNegResMsbs,
`ifdef FCVTINT_OVFCNT_EN
    output logic [31:0]            OvfCount,
`endif
    output logic                   RspValid,
    input  logic                   RspReady,
    output logic [XLEN-1:0]        RspRes,
    output logic                   RspNV,
    output logic                   RspNX
);
    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_CHECK, S_RESP} state_t;
    state_t                   r_state, w_next;
    logic                     r_signed, r_int64, r_plus1, r_xs, r_nan, r_fovf, r_inexact;
    logic [NORMSHIFTSZ-1:0]   r_shifted;
    logic [XLEN+1:0]          r_negres;
    logic [1:0]               r_msbs;
    logic [XLEN-1:0]          r_res;
    logic                     r_nv, r_nx;
    logic                     w_accept, w_w64, w_z, w_ovf;
    logic [63:0]              w_sx32, w_sat;
    logic [XLEN-1:0]          w_res;
    always_comb begin
        w_next = Flush ? S_IDLE :
                 (r_state == S_IDLE)  ? (ReqValid ? S_EVAL : S_IDLE) :
                 (r_state == S_EVAL)  ? S_CHECK :
                 (r_state == S_CHECK) ? S_RESP :
                 (RspReady ? S_IDLE : S_RESP);
        w_accept = (r_state == S_IDLE) && ReqValid && !Flush;
    end
    // With XLEN=32 the 64-bit destination does not exist, so Int64 is ignored.
    // 32-bit results (signed and unsigned alike) are sign-extended to XLEN.
    always_comb begin
        w_w64  = (XLEN == 64) && r_int64;
        w_z    = (r_negres == '0);
        w_ovf  = r_nan | r_fovf |
                 (r_signed ? (r_xs ? ((r_msbs != 2'b11) & ~w_z) : (r_msbs != 2'b00))
                           : (r_xs ? ~w_z : (r_msbs != 2'b00)));
        w_sx32 = {{32{r_negres[31]}}, r_negres[31:0]};
        w_sat  = (r_nan | ~r_xs)
                 ? (r_signed ? (w_w64 ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF) : '1)
                 : (r_signed ? (w_w64 ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000) : '0);
        w_res  = w_ovf ? XLEN'(w_sat) : (w_w64 ? r_negres[XLEN-1:0] : XLEN'(w_sx32));
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_signed  <= 1'b0;
            r_int64   <= 1'b0;
            r_plus1   <= 1'b0;
            r_xs      <= 1'b0;
            r_nan     <= 1'b0;
            r_fovf    <= 1'b0;
            r_inexact <= 1'b0;
            r_shifted <= '0;
            r_negres  <= '0;
            r_msbs    <= 2'b00;
            r_res     <= '0;
            r_nv      <= 1'b0;
            r_nx      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_signed  <= ReqSigned;
                r_int64   <= ReqInt64;
                r_plus1   <= ReqPlus1;
                r_xs      <= ReqXs;
                r_nan     <= ReqNaN;
                r_fovf    <= ReqForceOvf;
                r_inexact <= ReqInexact;
                r_shifted <= ReqShifted;
            end
            if (r_state == S_EVAL) begin
                r_negres <= DpNegRes;
                r_msbs   <= DpNegResMsbs;
            end
            if (r_state == S_CHECK) begin
                r_res <= w_res;
                r_nv  <= w_ovf;
                r_nx  <= r_inexact & ~w_ovf;
            end
        end
    end
`ifdef FCVTINT_OVFCNT_EN
    logic [31:0] r_ovfcnt;
    // Counts only completed NV responses; a flush in the handshake cycle cancels it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ovfcnt <= '0;
        else if ((r_state == S_RESP) && RspReady && r_nv && !Flush && (r_ovfcnt != '1))
            r_ovfcnt <= r_ovfcnt + 32'd1;
    end
    assign OvfCount = r_ovfcnt;
`endif
    assign ReqReady  = (r_state == S_IDLE);
    assign RspValid  = (r_state == S_RESP);
    assign DpSigned  = r_signed;
    assign DpInt64   = r_int64;
    assign DpPlus1   = r_plus1;
    assign DpXs      = r_xs;
    assign DpShifted = r_shifted;
    assign RspRes    = r_res;
    assign RspNV     = r_nv;
    assign RspNX     = r_nx;
endmodule

// File: tb/tb_fcvtint_seq.sv
// tb_fcvtint_seq: randomized self-checking bench for fcvtint_seq with a range-based reference model
module tb_fcvtint_seq;
    localparam int XLEN        = 64;
    localparam int NORMSHIFTSZ = 110;
    localparam int FW          = NORMSHIFTSZ - XLEN - 1;
    logic                   clk = 1'b0;
    logic                   reset_n, Flush, ReqValid, ReqReady;
    logic                   ReqSigned, ReqInt64, ReqPlus1, ReqXs, ReqNaN, ReqForceOvf, ReqInexact;
    logic [NORMSHIFTSZ-1:0] ReqShifted, DpShifted;
    logic                   DpSigned, DpInt64, DpPlus1, DpXs;
    logic [XLEN+1:0]        DpNegRes, dp_rnd;
    logic [1:0]             DpNegResMsbs;
    logic                   RspValid, RspReady, RspNV, RspNX;
    logic [XLEN-1:0]        RspRes;
`ifdef FCVTINT_OVFCNT_EN
    logic [31:0]            OvfCount;
`endif
    int checks   = 0;
    int failures = 0;
    int ovf_exp  = 0;

    fcvtint_seq #(.XLEN(XLEN), .NORMSHIFTSZ(NORMSHIFTSZ)) dut (
        .clk(clk), .reset_n(reset_n), .Flush(Flush),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqSigned(ReqSigned), .ReqInt64(ReqInt64), .ReqPlus1(ReqPlus1), .ReqXs(ReqXs),
        .ReqNaN(ReqNaN), .ReqForceOvf(ReqForceOvf), .ReqInexact(ReqInexact), .ReqShifted(ReqShifted),
        .DpSigned(DpSigned), .DpInt64(DpInt64), .DpPlus1(DpPlus1), .DpXs(DpXs), .DpShifted(DpShifted),
        .DpNegRes(DpNegRes), .DpNegResMsbs(DpNegResMsbs),
`ifdef FCVTINT_OVFCNT_EN
        .OvfCount(OvfCount),
`endif
        .RspValid(RspValid), .RspReady(RspReady), .RspRes(RspRes), .RspNV(RspNV), .RspNX(RspNX)
    );

    always #5 clk = ~clk;

    // Stand-in for the external datapath: integer part sits in the top XLEN+1 shifter bits.
    always_comb begin
        dp_rnd       = {1'b0, DpShifted[NORMSHIFTSZ-1 -: XLEN+1]} + {{(XLEN+1){1'b0}}, DpPlus1};
        DpNegRes     = DpXs ? -dp_rnd : dp_rnd;
        DpNegResMsbs = DpSigned ? (DpInt64 ? DpNegRes[XLEN:XLEN-1] : DpNegRes[32:31])
                                : (DpInt64 ? DpNegRes[XLEN+1:XLEN] : DpNegRes[33:32]);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: signed value of the rounded magnitude, clamped to the destination range.
    function automatic void model(input logic sgn, i64, p1, xs, nan, fovf, inex,
                                  input logic [127:0] mag,
                                  output logic [63:0] res, output logic nv, output logic nx);
        logic signed [127:0] r, v, lo, hi, o;
        int w;
        w  = i64 ? 64 : 32;
        r  = mag + {127'd0, p1};
        v  = xs ? -r : r;
        hi = sgn ? (128'sd1 <<< (w - 1)) - 128'sd1 : (128'sd1 <<< w) - 128'sd1;
        lo = sgn ? -(128'sd1 <<< (w - 1)) : 128'sd0;
        nv = nan | fovf | (v < lo) | (v > hi);
        o  = nv ? ((nan | ~xs) ? hi : lo) : v;
        res = (w == 32) ? {{32{o[31]}}, o[31:0]} : o[63:0];
        nx = inex & ~nv;
    endfunction

    function automatic logic [127:0] rmag(input int w);
        logic [127:0] m;
        int s;
        s = int'($urandom_range(0, 3));
        m = (s == 0) ? 128'd0 : (s == 1) ? (128'd1 << (w - 1)) : (s == 2) ? (128'd1 << w)
                     : {$urandom, $urandom, $urandom, $urandom};
        m = m + 128'($urandom_range(0, 4)) - ((s == 1 || s == 2) ? 128'd2 : 128'd0);
        return m & ((128'd1 << (w + 1)) - 128'd1);
    endfunction

    task automatic do_op(input logic sgn, i64, p1, xs, nan, fovf, inex,
                         input logic [127:0] mag, input int hold, output logic [65:0] got);
        logic [NORMSHIFTSZ-1:0] sh;
        logic [63:0]            eres;
        logic                   env, enx;
        int                     n;
        sh = {mag[XLEN:0], FW'({$urandom, $urandom})};
        model(sgn, i64, p1, xs, nan, fovf, inex, mag, eres, env, enx);
        {ReqSigned, ReqInt64, ReqPlus1, ReqXs, ReqNaN, ReqForceOvf, ReqInexact} = {sgn, i64, p1, xs, nan, fovf, inex};
        ReqShifted = sh;
        ReqValid   = 1'b1;
        chk("req_ready", 128'(ReqReady), 128'(1));
        @(posedge clk); #1;
        ReqValid   = 1'b0;
        ReqShifted = ~sh;
        ReqXs      = ~xs;
        chk("dp_shifted", 128'(DpShifted), 128'(sh));
        chk("dp_ctrl", 128'({DpSigned, DpInt64, DpPlus1, DpXs}), 128'({sgn, i64, p1, xs}));
        chk("busy", 128'(ReqReady), 128'(0));
        n = 1;
        while (!RspValid && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 128'(n), 128'(3));
        chk("rsp_res", 128'(RspRes), 128'(eres));
        chk("rsp_nv", 128'(RspNV), 128'(env));
        chk("rsp_nx", 128'(RspNX), 128'(enx));
        got = {RspNV, RspNX, RspRes};
        ReqValid = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 128'(RspValid), 128'(1));
            chk("hold_res", 128'(RspRes), 128'(eres));
            chk("hold_rdy", 128'(ReqReady), 128'(0));
        end
        RspReady = 1'b1;
        @(posedge clk); #1;
        RspReady = 1'b0;
        ReqValid = 1'b0;
        chk("post_idle", 128'({RspValid, ReqReady}), 128'(2'b01));
        if (env) ovf_exp++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [65:0] got;
        logic        sgn, i64, seen;
        reset_n = 1'b0; Flush = 1'b0; ReqValid = 1'b0; RspReady = 1'b0;
        {ReqSigned, ReqInt64, ReqPlus1, ReqXs, ReqNaN, ReqForceOvf, ReqInexact} = '0;
        ReqShifted = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 128'({ReqReady, RspValid}), 128'(2'b10));
        chk("rst_res", 128'({RspRes, RspNV, RspNX}), 128'(0));
        chk("rst_dp", 128'({DpShifted, DpSigned, DpInt64, DpPlus1, DpXs}), 128'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_op(1, 1, 1, 1, 0, 0, 0, 128'h5, 0, got);
        chk("l_neg6", 128'(got), 128'({2'b00, 64'hFFFF_FFFF_FFFF_FFFA}));
        do_op(1, 0, 0, 0, 0, 0, 0, 128'h8000_0000, 0, got);
        chk("w_pos_sat", 128'(got), 128'({2'b10, 64'h0000_0000_7FFF_FFFF}));
        do_op(1, 0, 0, 1, 0, 0, 0, 128'h8000_0000, 0, got);
        chk("w_min", 128'(got), 128'({2'b00, 64'hFFFF_FFFF_8000_0000}));
        do_op(0, 1, 0, 1, 0, 0, 0, 128'h7, 0, got);
        chk("lu_neg", 128'(got), 128'({2'b10, 64'h0}));
        do_op(0, 1, 0, 1, 0, 0, 1, 128'h0, 0, got);
        chk("lu_zero_nx", 128'(got), 128'({2'b01, 64'h0}));
        do_op(0, 0, 0, 0, 1, 0, 0, 128'h1234, 0, got);
        chk("wu_nan", 128'(got), 128'({2'b10, 64'hFFFF_FFFF_FFFF_FFFF}));
        do_op(1, 0, 0, 1, 0, 1, 0, 128'h3, 0, got);
        chk("w_inf_neg", 128'(got), 128'({2'b10, 64'hFFFF_FFFF_8000_0000}));
        do_op(1, 1, 0, 0, 0, 0, 1, 128'h42, 5, got);
        chk("hold_op", 128'(got), 128'({2'b01, 64'h42}));
        // Flush while the op is in EVAL: no response must follow.
        ReqNaN = 1'b1; ReqValid = 1'b1;
        @(posedge clk); #1;
        ReqValid = 1'b0; Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0; seen = 1'b0;
        repeat (6) begin
            seen = seen | RspValid;
            @(posedge clk); #1;
        end
        chk("flush_norsp", 128'(seen), 128'(0));
        chk("flush_idle", 128'(ReqReady), 128'(1));
        do_op(1, 1, 0, 0, 0, 0, 0, 128'h99, 0, got);
        chk("after_flush", 128'(got), 128'({2'b00, 64'h99}));
        // Reset asserted while the op is in CHECK.
        ReqNaN = 1'b1; ReqShifted = '1; ReqValid = 1'b1;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_hs", 128'({ReqReady, RspValid}), 128'(2'b10));
        chk("mid_rst_out", 128'({RspRes, RspNV, RspNX, DpSigned, DpInt64, DpPlus1, DpXs}), 128'(0));
        chk("mid_rst_dp", 128'(DpShifted), 128'(0));
        #2 reset_n = 1'b1;
        ovf_exp = 0;
        ReqNaN  = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 150; i++) begin
            sgn = 1'($urandom);
            i64 = 1'($urandom);
            do_op(sgn, i64, 1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0), 1'($urandom), rmag(i64 ? 64 : 32),
                  int'($urandom_range(0, 2)), got);
        end
`ifdef FCVTINT_OVFCNT_EN
        chk("ovf_count", 128'(OvfCount), 128'(ovf_exp));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
